fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Upstream neighbour of the instruction register stage in the multicycle RV32 core. Owns the PC register and runs the instruction-memory read transaction. Delivers the fetched word together with a one-cycle IRWrite strobe and the PC it was fetched from. Detects misaligned-PC, bus-error and bus-timeout faults and reports them to the control FSM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 255, maximum WAIT cycles before a timeout fault; legal range 1..255, 8-bit counter

Ports:
clk  in  1  core clock, all state changes on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
fetch_start  in  1  level request from the control FSM for the next instruction
pc_write  in  1  load pc_next into PC; covers sequential +4 and branch/jump/trap redirect
pc_next  in  32  new PC value
fault_clear  in  1  acknowledge a fault and return to IDLE
mem_req  out  1  read request to instruction memory
mem_addr  out  32  word address of the read; equals PC
mem_ready  in  1  memory response valid this cycle
mem_rdata  in  32  instruction word, valid with mem_ready
mem_err  in  1  bus error, qualified by mem_ready
ir_write  out  1  one-cycle strobe: instr and fetch_pc valid, IR stage captures
instr  out  32  registered fetched word; feeds the IR stage RD input
fetch_pc  out  32  PC of the word in instr; feeds the IR stage PC input
pc  out  32  current PC register
fetch_busy  out  1  high in WAIT and DELIVER
fetch_fault  out  1  high while in FAULT
fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout, 00 none

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: pc=RESET_PC; instr=0; fetch_pc=0; ir_write=0; mem_req=0; fetch_fault=0; fault_cause=00; state=IDLE; timeout counter=0; pending-PC valid=0.
- States: IDLE, WAIT, DELIVER, FAULT. mem_addr is always equal to pc.
- IDLE:
  - pc_write=1: pc<=pc_next. fetch_start is ignored that cycle; this is the priority rule.
  - Otherwise fetch_start=1 and pc[1:0]!=0: go to FAULT, cause=01, no mem_req.
  - Otherwise fetch_start=1: go to WAIT, counter<=0.
- WAIT:
  - mem_req=1, combinationally decoded from the state, held until mem_ready.
  - mem_ready=1 and mem_err=0: instr<=mem_rdata, fetch_pc<=pc, go to DELIVER.
  - mem_ready=1 and mem_err=1: go to FAULT, cause=10, instr unchanged.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and mem_ready=0, go to FAULT, cause=11.
  - mem_ready in the same cycle as the timeout threshold: the response wins.
- DELIVER:
  - ir_write=1 for exactly one cycle. Unconditional transition to IDLE.
  - First-request-to-strobe latency is 2 cycles when mem_ready returns in the first WAIT cycle.
- pc_write while busy (WAIT or DELIVER):
  - pc_next is captured into a one-entry pending register. pc is not changed mid-transaction.
  - The pending value is applied on entry to IDLE.
  - A second pc_write before application overwrites the pending value; last wins.
- FAULT:
  - fetch_fault=1 and fault_cause is held. No mem_req. fetch_start is ignored.
  - pc_write is applied directly (trap vector redirect).
  - fault_clear=1: go to IDLE and clear fault_cause to 00.
  - fault_clear and pc_write in the same cycle: both take effect.
- Reset mid-transaction: the state machine returns to IDLE immediately and mem_req drops asynchronously. The memory side must tolerate an abandoned request.
- ir_write is never asserted in any state other than DELIVER. instr and fetch_pc change only on a successful response.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, WAIT=2'd1, DELIVER=2'd2, FAULT=2'd3
  - fault-cause constants: CAUSE_NONE, CAUSE_MISALIGN, CAUSE_BUSERR, CAUSE_TIMEOUT
  - the RV32 NOP constant 32'h0000_0013, reused by decode
- One natural sub-module, fetch_timeout_counter: 8-bit counter with clear, enable and terminal-count output, reused later by the data-memory sequencer.

Test Plan:
- Reset, then fetch_start with mem_ready on the first WAIT cycle and mem_rdata=32'h00500093 -> mem_req high 1 cycle at addr 0; ir_write pulses 1 cycle later with instr=00500093 and fetch_pc=0.
- pc_write with pc_next=32'h40 in IDLE, then fetch_start with mem_ready delayed 5 cycles -> mem_addr=0x40 held 6 cycles; ir_write once; fetch_busy high throughout.
- pc_write with pc_next=32'h80 during WAIT -> pc stays 0x40 until DELIVER ends, then becomes 0x80; fetch_pc=0x40.
- pc_next=32'h42, then fetch_start -> FAULT with cause=01 and no mem_req; fault_clear together with pc_write of 0x100 -> IDLE with pc=0x100.
- mem_ready=1 with mem_err=1 -> FAULT with cause=10, no ir_write, instr unchanged. Separately, TIMEOUT_CYCLES=4 with no ready -> FAULT with cause=11 after 4 WAIT cycles.
- Assert reset in the middle of WAIT -> mem_req drops without a clock edge; pc=RESET_PC; a subsequent fetch completes normally.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encoding, fault causes and constants for instruction fetch
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2,
    FAULT   = 2'd3
  } fetch_state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - 8-bit wait-cycle counter with clear, enable and terminal-count flag
module fetch_timeout_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic [7:0] terminal_i,
  output logic       tc_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign tc_o = (count_q == terminal_i);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-memory read sequencer with fault detection
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  input  logic        fault_clear,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        ir_write,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] pc,
  output logic        fetch_busy,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t state_q;
  logic [31:0]  pc_q, instr_q, fetch_pc_q, pend_pc_q;
  logic         pend_valid_q;
  logic [1:0]   cause_q;
  logic         cnt_clear, cnt_en, cnt_tc;

  assign cnt_clear = (state_q == IDLE) && !pc_write && fetch_start && !pc_misaligned(pc_q[1:0]);
  assign cnt_en    = (state_q == WAIT) && !mem_ready;

  fetch_timeout_counter u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_en),
    .terminal_i (TC_LAST),
    .tc_o       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      fetch_pc_q   <= 32'd0;
      pend_pc_q    <= 32'd0;
      pend_valid_q <= 1'b0;
      cause_q      <= CAUSE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_write) begin
            pc_q <= pc_next;
          end else if (fetch_start) begin
            if (pc_misaligned(pc_q[1:0])) begin
              state_q <= FAULT;
              cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // Redirects during a transaction are parked so mem_addr stays stable.
          if (pc_write) begin
            pend_pc_q    <= pc_next;
            pend_valid_q <= 1'b1;
          end
          if (mem_ready) begin
            if (mem_err) begin
              state_q <= FAULT;
              cause_q <= CAUSE_BUSERR;
            end else begin
              instr_q    <= mem_rdata;
              fetch_pc_q <= pc_q;
              state_q    <= DELIVER;
            end
          end else if (cnt_tc) begin
            state_q <= FAULT;
            cause_q <= CAUSE_TIMEOUT;
          end
        end
        DELIVER: begin
          state_q      <= IDLE;
          pend_valid_q <= 1'b0;
          if (pc_write) begin
            pc_q <= pc_next;
          end else if (pend_valid_q) begin
            pc_q <= pend_pc_q;
          end
        end
        FAULT: begin
          // A direct trap redirect supersedes anything parked during the failed fetch.
          if (pc_write) begin
            pc_q         <= pc_next;
            pend_valid_q <= 1'b0;
          end
          if (fault_clear) begin
            state_q      <= IDLE;
            cause_q      <= CAUSE_NONE;
            pend_valid_q <= 1'b0;
            if (!pc_write && pend_valid_q) begin
              pc_q <= pend_pc_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = (state_q == WAIT);
  assign mem_addr    = pc_q;
  assign ir_write    = (state_q == DELIVER);
  assign instr       = instr_q;
  assign fetch_pc    = fetch_pc_q;
  assign pc          = pc_q;
  assign fetch_busy  = (state_q == WAIT) || (state_q == DELIVER);
  assign fetch_fault = (state_q == FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk, reset, fetch_start, pc_write, fault_clear;
  logic [31:0] pc_next, mem_rdata;
  logic        mem_ready, mem_err;

  logic        mem_req, ir_write, fetch_busy, fetch_fault;
  logic [31:0] mem_addr, instr, fetch_pc, pc;
  logic [1:0]  fault_cause;

  logic        t_mem_req, t_ir_write, t_fetch_busy, t_fetch_fault;
  logic [31:0] t_mem_addr, t_instr, t_fetch_pc, t_pc;
  logic [1:0]  t_fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_next(pc_next), .fault_clear(fault_clear), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err), .ir_write(ir_write),
    .instr(instr), .fetch_pc(fetch_pc), .pc(pc), .fetch_busy(fetch_busy),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  fetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_next(pc_next), .fault_clear(fault_clear), .mem_req(t_mem_req), .mem_addr(t_mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err), .ir_write(t_ir_write),
    .instr(t_instr), .fetch_pc(t_fetch_pc), .pc(t_pc), .fetch_busy(t_fetch_busy),
    .fetch_fault(t_fetch_fault), .fault_cause(t_fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_start = 0; pc_write = 0; pc_next = 0; fault_clear = 0;
    mem_ready = 0; mem_err = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #3;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
    n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h expected %h", fetch_pc, 32'h0); end
    n_checks++; if ({mem_req, ir_write, fetch_busy, fetch_fault} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {mem_req, ir_write, fetch_busy, fetch_fault}); end
    n_checks++; if (fault_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %b expected 00", fault_cause); end
    do_reset();
  endtask

  task automatic test_basic_fetch();
    fetch_start = 1;
    tick();
    fetch_start = 0;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr: got %h expected %h", mem_addr, 32'h0); end
    n_checks++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL basic_early_irw: got %b expected 0", ir_write); end
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ready = 0; mem_rdata = 32'h0;
    n_checks++; if (ir_write !== 1'b1) begin n_fail++; $display("FAIL basic_irw: got %b expected 1", ir_write); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %b expected 0", mem_req); end
    n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr: got %h expected %h", instr, 32'h0050_0093); end
    n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL basic_fetch_pc: got %h expected %h", fetch_pc, 32'h0); end
    tick();
    n_checks++; if ({ir_write, fetch_busy} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got %b expected 00", {ir_write, fetch_busy}); end
  endtask

  task automatic test_delayed();
    pc_write = 1; pc_next = 32'h40;
    tick();
    pc_write = 0; pc_next = 0;
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL delay_pc_load: got %h expected %h", pc, 32'h40); end
    fetch_start = 1;
    tick();
    fetch_start = 0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if ({mem_req, fetch_busy, ir_write} !== 3'b110) begin n_fail++; $display("FAIL delay_wait_flags[%0d]: got %b expected 110", i, {mem_req, fetch_busy, ir_write}); end
      n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL delay_addr[%0d]: got %h expected %h", i, mem_addr, 32'h40); end
      if (i == 5) begin mem_ready = 1; mem_rdata = 32'h0010_0113; end
      tick();
    end
    mem_ready = 0; mem_rdata = 0;
    n_checks++; if ({ir_write, fetch_busy, mem_req} !== 3'b110) begin n_fail++; $display("FAIL delay_deliver: got %b expected 110", {ir_write, fetch_busy, mem_req}); end
    n_checks++; if (instr !== 32'h0010_0113) begin n_fail++; $display("FAIL delay_instr: got %h expected %h", instr, 32'h0010_0113); end
    n_checks++; if (fetch_pc !== 32'h40) begin n_fail++; $display("FAIL delay_fetch_pc: got %h expected %h", fetch_pc, 32'h40); end
    tick();
    n_checks++; if ({ir_write, fetch_busy} !== 2'b00) begin n_fail++; $display("FAIL delay_single_strobe: got %b expected 00", {ir_write, fetch_busy}); end
  endtask

  task automatic test_pending();
    fetch_start = 1;
    tick();
    fetch_start = 0;
    pc_write = 1; pc_next = 32'h90;
    tick();
    pc_next = 32'h80;
    tick();
    pc_write = 0; pc_next = 0;
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL pend_pc_held: got %h expected %h", pc, 32'h40); end
    n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL pend_addr_held: got %h expected %h", mem_addr, 32'h40); end
    mem_ready = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ready = 0; mem_rdata = 0;
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL pend_pc_deliver: got %h expected %h", pc, 32'h40); end
    n_checks++; if (fetch_pc !== 32'h40) begin n_fail++; $display("FAIL pend_fetch_pc: got %h expected %h", fetch_pc, 32'h40); end
    tick();
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL pend_pc_applied: got %h expected %h", pc, 32'h80); end
  endtask

  task automatic test_misalign();
    pc_write = 1; pc_next = 32'h42;
    tick();
    pc_write = 0; pc_next = 0;
    fetch_start = 1;
    tick();
    n_checks++; if ({fetch_fault, mem_req} !== 2'b10) begin n_fail++; $display("FAIL mis_fault: got %b expected 10", {fetch_fault, mem_req}); end
    n_checks++; if (fault_cause !== 2'b01) begin n_fail++; $display("FAIL mis_cause: got %b expected 01", fault_cause); end
    tick();
    n_checks++; if ({fetch_fault, mem_req, fetch_busy} !== 3'b100) begin n_fail++; $display("FAIL mis_start_ignored: got %b expected 100", {fetch_fault, mem_req, fetch_busy}); end
    fetch_start = 0;
    fault_clear = 1; pc_write = 1; pc_next = 32'h100;
    tick();
    clear_inputs();
    n_checks++; if ({fetch_fault, fault_cause} !== 3'b000) begin n_fail++; $display("FAIL mis_cleared: got %b expected 000", {fetch_fault, fault_cause}); end
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL mis_redirect: got %h expected %h", pc, 32'h100); end
  endtask

  task automatic test_bus_error();
    fetch_start = 1;
    tick();
    fetch_start = 0;
    mem_ready = 1; mem_err = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (ir_write !== 1'b0) begin n_fail++; $display("FAIL berr_no_irw: got %b expected 0", ir_write); end
    mem_ready = 0; mem_err = 0; mem_rdata = 0;
    n_checks++; if ({fetch_fault, fault_cause} !== 3'b110) begin n_fail++; $display("FAIL berr_cause: got %b expected 110", {fetch_fault, fault_cause}); end
    n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL berr_instr_kept: got %h expected %h", instr, 32'h0000_0013); end
    n_checks++; if (fetch_pc !== 32'h40) begin n_fail++; $display("FAIL berr_fetch_pc_kept: got %h expected %h", fetch_pc, 32'h40); end
    fault_clear = 1;
    tick();
    fault_clear = 0;
    n_checks++; if ({fetch_fault, pc} !== {1'b0, 32'h100}) begin n_fail++; $display("FAIL berr_clear: got %b/%h expected 0/%h", fetch_fault, pc, 32'h100); end
  endtask

  task automatic test_timeout();
    do_reset();
    fetch_start = 1;
    tick();
    fetch_start = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({t_mem_req, t_fetch_fault} !== 2'b10) begin n_fail++; $display("FAIL to_waiting[%0d]: got %b expected 10", i, {t_mem_req, t_fetch_fault}); end
      tick();
    end
    n_checks++; if ({t_fetch_fault, t_mem_req} !== 2'b10) begin n_fail++; $display("FAIL to_fault: got %b expected 10", {t_fetch_fault, t_mem_req}); end
    n_checks++; if (t_fault_cause !== 2'b11) begin n_fail++; $display("FAIL to_cause: got %b expected 11", t_fault_cause); end
    n_checks++; if ({mem_req, fetch_fault} !== 2'b10) begin n_fail++; $display("FAIL to_long_still_wait: got %b expected 10", {mem_req, fetch_fault}); end
    do_reset();
    fetch_start = 1;
    tick();
    fetch_start = 0;
    tick(); tick(); tick();
    mem_ready = 1; mem_rdata = 32'h0020_0193;
    tick();
    mem_ready = 0; mem_rdata = 0;
    n_checks++; if ({t_ir_write, t_fetch_fault} !== 2'b10) begin n_fail++; $display("FAIL to_ready_wins: got %b expected 10", {t_ir_write, t_fetch_fault}); end
    n_checks++; if (t_instr !== 32'h0020_0193) begin n_fail++; $display("FAIL to_ready_instr: got %h expected %h", t_instr, 32'h0020_0193); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    pc_write = 1; pc_next = 32'h200;
    tick();
    pc_write = 0; pc_next = 0;
    fetch_start = 1;
    tick();
    fetch_start = 0;
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL rst_mid_pre: got %b/%h expected 1/%h", mem_req, mem_addr, 32'h200); end
    #2 reset = 1;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req_drop: got %b expected 0", mem_req); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pc: got %h expected %h", pc, 32'h0); end
    #1 reset = 0;
    tick();
    fetch_start = 1;
    tick();
    fetch_start = 0;
    mem_ready = 1; mem_rdata = 32'h0010_0073;
    tick();
    mem_ready = 0; mem_rdata = 0;
    n_checks++; if ({ir_write, instr} !== {1'b1, 32'h0010_0073}) begin n_fail++; $display("FAIL rst_mid_refetch: got %b/%h expected 1/%h", ir_write, instr, 32'h0010_0073); end
    n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_fetch_pc: got %h expected %h", fetch_pc, 32'h0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_delayed();
    test_pending();
    test_misalign();
    test_bus_error();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
